// File: rtl/cipher_sequencer_pkg.sv
// Shared types and sizing helpers for the stream-cipher interface sequencer.
package cipher_sequencer_pkg;

  typedef enum logic [2:0] {
    I_IDLE,
    I_KEYLOAD,
    I_KEY_NEXT,
    I_KS_WAIT,
    I_ENCRYPT,
    I_WAIT_OUT,
    I_HOLD
  } interface_state_t;

  typedef enum logic {
    O_EMPTY,
    O_READY
  } output_holder_state_t;

  // Index width that stays legal (>=1 bit) even for a single-entry range.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cipher_sequencer_timeout.sv
// Saturating keystream-wait timer; expired flags the last allowed wait cycle.
module seq_timeout_counter #(
  parameter int unsigned KS_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned TW = $clog2(KS_TIMEOUT + 1);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != TW'(KS_TIMEOUT))) begin
      count_q <= count_q + TW'(1);
    end
  end

  // The wait cycle in which the count reaches KS_TIMEOUT is the final one.
  assign expired = enable && (count_q == TW'(KS_TIMEOUT - 1));

endmodule

// File: rtl/cipher_sequencer.sv
// Interface FSM of the stream cipher: sequences key loads and single-byte
// encryptions between the user port, keystream generator and output holder.
module cipher_sequencer
  import cipher_sequencer_pkg::*;
#(
  parameter int unsigned KEY_BYTES  = 16,
  parameter int unsigned KS_TIMEOUT = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             usr_valid,
  input  logic                             usr_mode,
  input  logic [7:0]                       usr_data,
  input  logic                             usr_read_ack,
  output logic                             usr_ready,
  output logic                             usr_err,
  output logic                             ks_key_we,
  output logic [cnt_width(KEY_BYTES)-1:0]  ks_key_idx,
  output logic [7:0]                       ks_key_data,
  output logic                             ks_init,
  output logic                             ks_req,
  input  logic                             ks_ack,
  output logic                             enc_pulse,
  output logic [7:0]                       enc_data,
  input  output_holder_state_t             holder_state,
  output interface_state_t                 interface_state
);
  localparam int unsigned IDX_W = cnt_width(KEY_BYTES);

  interface_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       key_data_q, key_data_d;
  logic [7:0]       enc_data_q, enc_data_d;
  logic             usr_err_q, usr_err_d;
  logic             ks_init_q, ks_init_d;
  logic             tmr_clear, tmr_expired;
  logic             accept_key, accept_enc;

  seq_timeout_counter #(.KS_TIMEOUT(KS_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (state_q == I_KS_WAIT),
    .expired (tmr_expired)
  );

  // Key bytes are taken in both ready states; plaintext only from idle.
  assign accept_key = usr_valid && usr_mode &&
                      ((state_q == I_IDLE) || (state_q == I_KEY_NEXT));
  assign accept_enc = usr_valid && !usr_mode && (state_q == I_IDLE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    key_data_d = key_data_q;
    enc_data_d = enc_data_q;
    usr_err_d  = usr_err_q;
    ks_init_d  = 1'b0;
    tmr_clear  = 1'b0;

    if (accept_key || accept_enc) usr_err_d = 1'b0;

    unique case (state_q)
      I_IDLE: begin
        if (accept_key) begin
          key_data_d = usr_data;
          state_d    = I_KEYLOAD;
        end else if (accept_enc) begin
          enc_data_d = usr_data;
          tmr_clear  = 1'b1;
          state_d    = I_KS_WAIT;
        end
      end
      I_KEYLOAD: begin
        if (idx_q == IDX_W'(KEY_BYTES - 1)) begin
          idx_d     = '0;
          ks_init_d = 1'b1;
          state_d   = I_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = I_KEY_NEXT;
        end
      end
      I_KEY_NEXT: begin
        if (accept_key) begin
          key_data_d = usr_data;
          state_d    = I_KEYLOAD;
        end
      end
      I_KS_WAIT: begin
        if (ks_ack) begin
          state_d = I_ENCRYPT;
        end else if (tmr_expired) begin
          usr_err_d = 1'b1;
          state_d   = I_IDLE;
        end
      end
      I_ENCRYPT:  state_d = I_WAIT_OUT;
      I_WAIT_OUT: if (holder_state == O_READY) state_d = I_HOLD;
      I_HOLD:     if (usr_read_ack) state_d = I_IDLE;
      default:    state_d = I_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= I_IDLE;
      idx_q      <= '0;
      key_data_q <= '0;
      enc_data_q <= '0;
      usr_err_q  <= 1'b0;
      ks_init_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      key_data_q <= key_data_d;
      enc_data_q <= enc_data_d;
      usr_err_q  <= usr_err_d;
      ks_init_q  <= ks_init_d;
    end
  end

  assign usr_ready       = (state_q == I_IDLE) || (state_q == I_KEY_NEXT);
  assign usr_err         = usr_err_q;
  assign ks_key_we       = (state_q == I_KEYLOAD);
  assign ks_key_idx      = idx_q;
  assign ks_key_data     = key_data_q;
  assign ks_init         = ks_init_q;
  assign ks_req          = (state_q == I_KS_WAIT);
  assign enc_pulse       = (state_q == I_ENCRYPT);
  assign enc_data        = enc_data_q;
  assign interface_state = state_q;

endmodule

// File: tb/tb_cipher_sequencer.sv
// Scoreboard bench for cipher_sequencer: key writes and encrypt pulses are
// matched against expectations queued when the stimulus is driven.
module tb_cipher_sequencer;
  import cipher_sequencer_pkg::*;

  localparam int unsigned KEY_BYTES  = 16;
  localparam int unsigned KS_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic usr_valid = 1'b0, usr_mode = 1'b0, usr_read_ack = 1'b0, ks_ack = 1'b0;
  logic [7:0] usr_data = 8'h00;
  logic usr_ready, usr_err, ks_key_we, ks_init, ks_req, enc_pulse;
  logic [3:0] ks_key_idx;
  logic [7:0] ks_key_data, enc_data;
  output_holder_state_t holder;
  interface_state_t     ifs;

  int checks = 0;
  int errors = 0;
  int key_we_count = 0, ks_init_count = 0, enc_count = 0;
  logic prev_last_we = 1'b0;
  logic holder_pend;
  logic [15:0] key_q[$];
  logic [7:0]  enc_q[$];

  cipher_sequencer #(.KEY_BYTES(KEY_BYTES), .KS_TIMEOUT(KS_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .usr_valid(usr_valid), .usr_mode(usr_mode),
    .usr_data(usr_data), .usr_read_ack(usr_read_ack), .usr_ready(usr_ready),
    .usr_err(usr_err), .ks_key_we(ks_key_we), .ks_key_idx(ks_key_idx),
    .ks_key_data(ks_key_data), .ks_init(ks_init), .ks_req(ks_req),
    .ks_ack(ks_ack), .enc_pulse(enc_pulse), .enc_data(enc_data),
    .holder_state(holder), .interface_state(ifs)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output holder: loads two cycles after enc_pulse, clears after read-ack in hold.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      holder_pend <= 1'b0;
      holder      <= O_EMPTY;
    end else begin
      holder_pend <= enc_pulse;
      if (holder_pend) holder <= O_READY;
      else if (ifs == I_HOLD && usr_read_ack) holder <= O_EMPTY;
    end
  end

  always @(negedge clk) begin
    if (ks_key_we) begin
      key_we_count++;
      if (key_q.size() == 0) check_eq("key_unexpected", 32'd1, 32'd0);
      else begin
        logic [15:0] e;
        e = key_q.pop_front();
        $display("key write idx=%0d data=0x%02h", ks_key_idx, ks_key_data);
        check_eq("key_idx", 32'(ks_key_idx), 32'(e[15:8]));
        check_eq("key_data", 32'(ks_key_data), 32'(e[7:0]));
      end
    end
    if (ks_init) begin
      ks_init_count++;
      $display("ks_init pulse");
      check_eq("ks_init_after_last", 32'(prev_last_we), 32'd1);
    end
    prev_last_we = ks_key_we && (ks_key_idx == 4'(KEY_BYTES - 1));
    if (enc_pulse) begin
      enc_count++;
      if (enc_q.size() == 0) check_eq("enc_unexpected", 32'd1, 32'd0);
      else begin
        logic [7:0] e;
        e = enc_q.pop_front();
        $display("encrypt pulse data=0x%02h", enc_data);
        check_eq("enc_data", 32'(enc_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!usr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!usr_ready) check_eq("ready_timeout", 32'(usr_ready), 32'd1);
  endtask

  task automatic send(input logic mode, input logic [7:0] data);
    wait_ready();
    usr_valid = 1'b1;
    usr_mode  = mode;
    usr_data  = data;
    tick();
    usr_valid = 1'b0;
  endtask

  task automatic wait_state(input interface_state_t s, input string tag);
    int n = 0;
    while (ifs != s && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(ifs), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) tick();
    check_eq("rst_state", 32'(ifs), 32'(I_IDLE));
    check_eq("rst_ready", 32'(usr_ready), 32'd1);
    check_eq("rst_outputs", {26'd0, usr_err, ks_key_we, ks_init, ks_req, enc_pulse, 1'b0}, 32'd0);
    check_eq("rst_idx", 32'(ks_key_idx), 32'd0);
    check_eq("rst_enc_data", 32'(enc_data), 32'd0);
    rst = 1'b0;
    tick();

    // Full key load with a stray plaintext strobe in the middle.
    for (int i = 0; i < KEY_BYTES; i++) begin
      key_q.push_back({8'(i), 8'(i)});
      send(1'b1, 8'(i));
      if (i == 5) begin
        tick();
        usr_valid = 1'b1; usr_mode = 1'b0; usr_data = 8'hEE;
        tick();
        usr_valid = 1'b0;
        check_eq("key_next_ignore_enc", 32'(ifs), 32'(I_KEY_NEXT));
      end
    end
    tick();
    check_eq("key_done_state", 32'(ifs), 32'(I_IDLE));
    check_eq("key_done_idx", 32'(ks_key_idx), 32'd0);
    tick();
    check_eq("ks_init_count", 32'(ks_init_count), 32'd1);
    check_eq("key_we_count", 32'(key_we_count), 32'(KEY_BYTES));

    // Encrypt 0xA5 with immediate keystream ack.
    enc_q.push_back(8'hA5);
    send(1'b0, 8'hA5);
    check_eq("enc_kswait", 32'(ifs), 32'(I_KS_WAIT));
    check_eq("enc_ks_req", 32'(ks_req), 32'd1);
    ks_ack = 1'b1;
    tick();
    ks_ack = 1'b0;
    check_eq("enc_pulse_c2", 32'(enc_pulse), 32'd1);
    check_eq("enc_data_a5", 32'(enc_data), 32'hA5);
    tick();
    check_eq("enc_pulse_single", 32'(enc_pulse), 32'd0);
    check_eq("wait_out", 32'(ifs), 32'(I_WAIT_OUT));
    usr_valid = 1'b1; usr_mode = 1'b0; usr_data = 8'h3C;
    tick();
    check_eq("holder_ready_c4", 32'(holder), 32'(O_READY));
    check_eq("wait_out_ignore", 32'(ifs), 32'(I_WAIT_OUT));
    tick();
    check_eq("hold_state", 32'(ifs), 32'(I_HOLD));
    check_eq("hold_not_ready", 32'(usr_ready), 32'd0);
    tick();
    check_eq("hold_ignore_valid", 32'(ifs), 32'(I_HOLD));
    check_eq("hold_enc_data", 32'(enc_data), 32'hA5);
    usr_valid = 1'b0;
    usr_read_ack = 1'b1;
    tick();
    usr_read_ack = 1'b0;
    check_eq("read_ack_idle", 32'(ifs), 32'(I_IDLE));
    tick();
    check_eq("holder_cleared", 32'(holder), 32'(O_EMPTY));

    // Keystream never arrives: abort after KS_TIMEOUT wait cycles.
    send(1'b0, 8'h11);
    n = 0;
    while (ifs == I_KS_WAIT && n < 20) begin
      tick();
      n++;
    end
    check_eq("timeout_cycles", 32'(n), 32'(KS_TIMEOUT));
    check_eq("timeout_state", 32'(ifs), 32'(I_IDLE));
    check_eq("timeout_err", 32'(usr_err), 32'd1);
    check_eq("timeout_ks_req", 32'(ks_req), 32'd0);

    // Ack arriving on the final wait cycle wins over the timeout.
    enc_q.push_back(8'h5A);
    send(1'b0, 8'h5A);
    check_eq("err_cleared", 32'(usr_err), 32'd0);
    repeat (KS_TIMEOUT - 1) tick();
    check_eq("last_wait_cycle", 32'(ifs), 32'(I_KS_WAIT));
    ks_ack = 1'b1;
    tick();
    ks_ack = 1'b0;
    check_eq("ack_on_timeout", 32'(ifs), 32'(I_ENCRYPT));
    check_eq("ack_on_timeout_err", 32'(usr_err), 32'd0);
    wait_state(I_HOLD, "second_hold");
    usr_read_ack = 1'b1;
    tick();
    usr_read_ack = 1'b0;
    check_eq("second_idle", 32'(ifs), 32'(I_IDLE));

    // Reset mid key load discards the partial key.
    key_q.push_back({8'd0, 8'hA0});
    send(1'b1, 8'hA0);
    key_q.push_back({8'd1, 8'hA1});
    send(1'b1, 8'hA1);
    tick();
    check_eq("partial_idx", 32'(ks_key_idx), 32'd2);
    rst = 1'b1;
    #1;
    check_eq("partial_rst_idx", 32'(ks_key_idx), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Asynchronous reset while waiting for keystream.
    send(1'b0, 8'h77);
    check_eq("pre_rst_ks_req", 32'(ks_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_state", 32'(ifs), 32'(I_IDLE));
    check_eq("async_rst_ks_req", 32'(ks_req), 32'd0);
    check_eq("async_rst_ready", 32'(usr_ready), 32'd1);
    check_eq("async_rst_enc_data", 32'(enc_data), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    check_eq("key_q_empty", 32'(key_q.size()), 32'd0);
    check_eq("enc_q_empty", 32'(enc_q.size()), 32'd0);
    check_eq("enc_count", 32'(enc_count), 32'd2);
    check_eq("ks_init_total", 32'(ks_init_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
